// File: rtl/wb_pkg.sv
// Shared writeback-path types and defaults used by the RW stage, MAC queue and port arbiter.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_STEAL  = 1'b1
  } arb_state_e;

  typedef enum logic [2:0] {
    OP_IMMEDIATE = 3'd0,
    OP_REG_REG   = 3'd1,
    OP_LOAD      = 3'd2,
    OP_STORE     = 3'd3,
    OP_BRANCH    = 3'd4,
    OP_MAC       = 3'd5
  } wb_opcode_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundles the RW-stage, MAC-unit, register-file and hazard signals around the write-port arbiter.
interface wb_port_arbiter_if
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W
) ();

  localparam int unsigned NREG = 1 << ADDR_W;

  logic              Pipe_Wr_En_In;
  logic [ADDR_W-1:0] Pipe_Wr_Addr_In;
  logic [DATA_W-1:0] Pipe_Wr_Data_In;
  logic              Pipe_Stall_Out;

  logic              Mac_Valid_In;
  logic              Mac_Ready_Out;
  logic [ADDR_W-1:0] Mac_Addr_In;
  logic [DATA_W-1:0] Mac_Data_In;

  logic              Rf_Wr_En_Out;
  logic [ADDR_W-1:0] Rf_Wr_Addr_Out;
  logic [DATA_W-1:0] Rf_Wr_Data_Out;

  logic [NREG-1:0]   Pending_Vec_Out;

  modport slave (
    input  Pipe_Wr_En_In, Pipe_Wr_Addr_In, Pipe_Wr_Data_In,
    input  Mac_Valid_In, Mac_Addr_In, Mac_Data_In,
    output Pipe_Stall_Out, Mac_Ready_Out,
    output Rf_Wr_En_Out, Rf_Wr_Addr_Out, Rf_Wr_Data_Out,
    output Pending_Vec_Out
  );

  modport master (
    output Pipe_Wr_En_In, Pipe_Wr_Addr_In, Pipe_Wr_Data_In,
    output Mac_Valid_In, Mac_Addr_In, Mac_Data_In,
    input  Pipe_Stall_Out, Mac_Ready_Out,
    input  Rf_Wr_En_Out, Rf_Wr_Addr_Out, Rf_Wr_Data_Out,
    input  Pending_Vec_Out
  );

endinterface

// File: rtl/wb_mac_queue.sv
// Circular MAC result queue with per-entry valid bits, address-match squash and a pending-register vector.
module wb_mac_queue
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W  = WB_DATA_W,
  parameter int unsigned ADDR_W  = WB_ADDR_W,
  parameter int unsigned Q_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_addr_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  input  logic                     squash_en_i,
  input  logic [ADDR_W-1:0]        squash_addr_i,
  output logic                     ready_c_o,
  output logic                     head_present_c_o,
  output logic                     head_valid_c_o,
  output logic [ADDR_W-1:0]        head_addr_c_o,
  output logic [DATA_W-1:0]        head_data_c_o,
  output logic [(1<<ADDR_W)-1:0]   pending_vec_c_o
);

  localparam int unsigned PTR_W = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [Q_DEPTH-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q [Q_DEPTH];
  logic [DATA_W-1:0]  data_q [Q_DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Squash first, then pop clears the head slot, then push claims the tail slot.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < int'(Q_DEPTH); i++) begin
      if (squash_en_i && (addr_q[i] == squash_addr_i)) valid_d[i] = 1'b0;
    end
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  always_comb begin
    ready_c_o        = (count_q < CNT_W'(Q_DEPTH));
    head_present_c_o = (count_q != '0);
    head_valid_c_o   = head_present_c_o && valid_q[head_q];
    head_addr_c_o    = addr_q[head_q];
    head_data_c_o    = data_q[head_q];
    pending_vec_c_o  = '0;
    for (int i = 0; i < int'(Q_DEPTH); i++) begin
      if (valid_q[i]) pending_vec_c_o[addr_q[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipe writes win, queued MAC results drain, periodic steal bounds MAC wait.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = WB_DATA_W,
  parameter int unsigned ADDR_W   = WB_ADDR_W,
  parameter int unsigned Q_DEPTH  = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned NREG  = 1 << ADDR_W;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              stall_q, stall_d;
  logic              rf_en_q, rf_en_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic              pipe_req, pipe_gnt, head_gnt, pop, push, squash_en;
  logic              q_ready, q_head_present, q_head_valid;
  logic [ADDR_W-1:0] q_head_addr;
  logic [DATA_W-1:0] q_head_data;
  logic [NREG-1:0]   q_pending;

  wb_mac_queue #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .Q_DEPTH (Q_DEPTH)
  ) u_queue (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_i           (push),
    .push_addr_i      (bus.Mac_Addr_In),
    .push_data_i      (bus.Mac_Data_In),
    .pop_i            (pop),
    .squash_en_i      (squash_en),
    .squash_addr_i    (bus.Pipe_Wr_Addr_In),
    .ready_c_o        (q_ready),
    .head_present_c_o (q_head_present),
    .head_valid_c_o   (q_head_valid),
    .head_addr_c_o    (q_head_addr),
    .head_data_c_o    (q_head_data),
    .pending_vec_c_o  (q_pending)
  );

  // Grant, pop, squash, wait-counter and next-state decision.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rf_en_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    pipe_gnt  = 1'b0;
    head_gnt  = 1'b0;
    pop       = 1'b0;
    squash_en = 1'b0;
    pipe_req  = bus.Pipe_Wr_En_In && (bus.Pipe_Wr_Addr_In != '0);

    case (state_q)
      ST_NORMAL: begin
        pipe_gnt  = pipe_req;
        head_gnt  = !pipe_req && q_head_valid;
        pop       = head_gnt || (q_head_present && !q_head_valid);
        squash_en = pipe_gnt;
        if (pop) begin
          wait_d = '0;
        end else if (q_head_valid) begin
          if (wait_q == CNT_W'(MAX_WAIT - 1)) begin
            state_d = ST_STEAL;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
      end
      ST_STEAL: begin
        head_gnt = q_head_valid;
        pop      = q_head_present;
        wait_d   = '0;
        state_d  = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase

    // A MAC result racing a granted pipe write to the same register is already stale.
    push = bus.Mac_Valid_In && q_ready && (bus.Mac_Addr_In != '0) &&
           !(squash_en && (bus.Mac_Addr_In == bus.Pipe_Wr_Addr_In));

    if (pipe_gnt) begin
      rf_en_d   = 1'b1;
      rf_addr_d = bus.Pipe_Wr_Addr_In;
      rf_data_d = bus.Pipe_Wr_Data_In;
    end else if (head_gnt) begin
      rf_en_d   = 1'b1;
      rf_addr_d = q_head_addr;
      rf_data_d = q_head_data;
    end

    stall_d = (state_d == ST_STEAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_NORMAL;
      wait_q    <= '0;
      stall_q   <= 1'b0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign bus.Pipe_Stall_Out  = stall_q;
  assign bus.Mac_Ready_Out   = q_ready;
  assign bus.Rf_Wr_En_Out    = rf_en_q;
  assign bus.Rf_Wr_Addr_Out  = rf_addr_q;
  assign bus.Rf_Wr_Data_Out  = rf_data_q;
  assign bus.Pending_Vec_Out = q_pending;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed test-plan scenarios plus randomized traffic checked every cycle against a queue-based model.
module tb_wb_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned QD = 2;
  localparam int unsigned MW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .Q_DEPTH(QD), .MAX_WAIT(MW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_steal;
  int            m_wait;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].v) p[mq[i].a] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_steal = 1'b0;
    m_wait  = 0;
    m_en    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock of the arbiter's rules, applied to the inputs held across the coming edge.
  task automatic model_step();
    bit pres, hv, preq, pg, hg, pop, push;
    pres = (mq.size() > 0);
    hv   = pres && mq[0].v;
    preq = bus.Pipe_Wr_En_In && (bus.Pipe_Wr_Addr_In != 0);
    if (!m_steal) begin
      pg  = preq;
      hg  = !preq && hv;
      pop = hg || (pres && !hv);
    end else begin
      pg  = 1'b0;
      hg  = hv;
      pop = pres;
    end
    m_en = pg || hg;
    if (pg) begin
      m_addr = bus.Pipe_Wr_Addr_In;
      m_data = bus.Pipe_Wr_Data_In;
    end else if (hg) begin
      m_addr = mq[0].a;
      m_data = mq[0].d;
    end
    push = bus.Mac_Valid_In && (mq.size() < QD) && (bus.Mac_Addr_In != 0) &&
           !(pg && bus.Mac_Addr_In == bus.Pipe_Wr_Addr_In);
    if (pg) foreach (mq[i]) if (mq[i].a == bus.Pipe_Wr_Addr_In) mq[i].v = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{v: 1'b1, a: bus.Mac_Addr_In, d: bus.Mac_Data_In});
    if (m_steal) begin
      m_steal = 1'b0;
      m_wait  = 0;
    end else if (pop) begin
      m_wait = 0;
    end else if (hv && !hg) begin
      if (m_wait == MW - 1) begin
        m_steal = 1'b1;
        m_wait  = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("m_en", bus.Rf_Wr_En_Out, m_en);
      if (m_en) begin
        chk("m_addr", bus.Rf_Wr_Addr_Out, m_addr);
        chk("m_data", bus.Rf_Wr_Data_Out, m_data);
      end
      chk("m_stall", bus.Pipe_Stall_Out, m_steal);
      chk("m_ready", bus.Mac_Ready_Out, (mq.size() < QD));
      chk("m_pend", bus.Pending_Vec_Out, model_pending());
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.Pipe_Wr_En_In   = en;
    bus.Pipe_Wr_Addr_In = a;
    bus.Pipe_Wr_Data_In = d;
  endtask

  task automatic drive_mac(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.Mac_Valid_In = v;
    bus.Mac_Addr_In  = a;
    bus.Mac_Data_In  = d;
  endtask

  task automatic idle();
    drive_pipe(1'b0, '0, '0);
    drive_mac(1'b0, '0, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    bus.Rf_Wr_En_Out,    1'b0);
    chk({tag, "_addr"},  bus.Rf_Wr_Addr_Out,  '0);
    chk({tag, "_data"},  bus.Rf_Wr_Data_Out,  '0);
    chk({tag, "_stall"}, bus.Pipe_Stall_Out,  1'b0);
    chk({tag, "_pend"},  bus.Pending_Vec_Out, '0);
    chk({tag, "_ready"}, bus.Mac_Ready_Out,   1'b1);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Plain pipe write.
    drive_pipe(1'b1, 5'd5, 32'hA5A5_0001);
    tick();
    chk("t1_en", bus.Rf_Wr_En_Out, 1'b1);
    chk("t1_addr", bus.Rf_Wr_Addr_Out, 5'd5);
    chk("t1_data", bus.Rf_Wr_Data_Out, 32'hA5A5_0001);
    chk("t1_pend", bus.Pending_Vec_Out, 32'h0);
    idle();
    tick();
    chk("t1_idle", bus.Rf_Wr_En_Out, 1'b0);

    // MAC result drains through the queue with the pipe idle.
    drive_mac(1'b1, 5'd7, 32'h1234);
    tick();
    chk("t2_pend", bus.Pending_Vec_Out, 32'h0000_0080);
    chk("t2_en0", bus.Rf_Wr_En_Out, 1'b0);
    idle();
    tick();
    chk("t2_en", bus.Rf_Wr_En_Out, 1'b1);
    chk("t2_addr", bus.Rf_Wr_Addr_Out, 5'd7);
    chk("t2_data", bus.Rf_Wr_Data_Out, 32'h1234);
    chk("t2_pend0", bus.Pending_Vec_Out, 32'h0);
    tick();

    // Full queue under a continuously writing pipe forces a steal.
    drive_pipe(1'b1, 5'd9, 32'h99);
    drive_mac(1'b1, 5'd3, 32'h33);
    tick();
    chk("t3_e1", bus.Rf_Wr_Addr_Out, 5'd9);
    drive_mac(1'b1, 5'd4, 32'h44);
    tick();
    chk("t3_ready", bus.Mac_Ready_Out, 1'b0);
    chk("t3_pend", bus.Pending_Vec_Out, 32'h0000_0018);
    drive_mac(1'b0, '0, '0);
    tick();
    chk("t3_nostall3", bus.Pipe_Stall_Out, 1'b0);
    tick();
    chk("t3_nostall4", bus.Pipe_Stall_Out, 1'b0);
    tick();
    chk("t3_stall", bus.Pipe_Stall_Out, 1'b1);
    chk("t3_e5", bus.Rf_Wr_Addr_Out, 5'd9);
    tick();
    chk("t3_stall_off", bus.Pipe_Stall_Out, 1'b0);
    chk("t3_x3_en", bus.Rf_Wr_En_Out, 1'b1);
    chk("t3_x3_addr", bus.Rf_Wr_Addr_Out, 5'd3);
    chk("t3_x3_data", bus.Rf_Wr_Data_Out, 32'h33);
    tick();
    chk("t3_x9_addr", bus.Rf_Wr_Addr_Out, 5'd9);
    chk("t3_x9_data", bus.Rf_Wr_Data_Out, 32'h99);
    idle();
    tick();
    chk("t3_x4_addr", bus.Rf_Wr_Addr_Out, 5'd4);
    chk("t3_x4_data", bus.Rf_Wr_Data_Out, 32'h44);
    chk("t3_drained", bus.Pending_Vec_Out, 32'h0);
    tick();

    // Queued x6 squashed by a later pipe write to x6.
    drive_pipe(1'b1, 5'd10, 32'hA0);
    drive_mac(1'b1, 5'd6, 32'h6666);
    tick();
    chk("t4_pend", bus.Pending_Vec_Out, 32'h0000_0040);
    drive_mac(1'b0, '0, '0);
    drive_pipe(1'b1, 5'd6, 32'hBEEF);
    tick();
    chk("t4_pend0", bus.Pending_Vec_Out, 32'h0);
    chk("t4_addr", bus.Rf_Wr_Addr_Out, 5'd6);
    chk("t4_data", bus.Rf_Wr_Data_Out, 32'hBEEF);
    idle();
    tick();
    chk("t4_nowrite", bus.Rf_Wr_En_Out, 1'b0);
    tick();
    chk("t4_nowrite2", bus.Rf_Wr_En_Out, 1'b0);

    // Same-cycle MAC and pipe to x8, then x0 on both sides.
    drive_pipe(1'b1, 5'd8, 32'h8888);
    drive_mac(1'b1, 5'd8, 32'h8080);
    #1;
    chk("t5_ready", bus.Mac_Ready_Out, 1'b1);
    tick();
    chk("t5_addr", bus.Rf_Wr_Addr_Out, 5'd8);
    chk("t5_data", bus.Rf_Wr_Data_Out, 32'h8888);
    chk("t5_pend", bus.Pending_Vec_Out, 32'h0);
    idle();
    tick();
    chk("t5_nowrite", bus.Rf_Wr_En_Out, 1'b0);
    drive_pipe(1'b1, 5'd0, 32'h1111);
    drive_mac(1'b1, 5'd0, 32'h2222);
    tick();
    chk("t5_x0_en", bus.Rf_Wr_En_Out, 1'b0);
    chk("t5_x0_pend", bus.Pending_Vec_Out, 32'h0);
    idle();
    tick();
    chk("t5_x0_en2", bus.Rf_Wr_En_Out, 1'b0);

    // Asynchronous reset with two entries queued.
    drive_pipe(1'b1, 5'd12, 32'hC);
    drive_mac(1'b1, 5'd11, 32'hB);
    tick();
    drive_mac(1'b1, 5'd13, 32'hD);
    tick();
    chk("t6_ready", bus.Mac_Ready_Out, 1'b0);
    chk("t6_pend", bus.Pending_Vec_Out, 32'h0000_2800);
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6rst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_nowrite", bus.Rf_Wr_En_Out, 1'b0);
    end
    chk("t6_ready_after", bus.Mac_Ready_Out, 1'b1);

    // Randomized traffic; the RW stage holds its request while stalled.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.Pipe_Stall_Out)
        drive_pipe(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      drive_mac(1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)), $urandom);
      tick();
    end
    idle();
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
